// File: rtl/nvr_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// nvr_mem_ctrl_if
//
// Request/response bus between the datapath (load/store unit) and the NVR
// memory sequencer.
//
// Parameters:
//   ADDR_W    - NVR word address width
//   DATA_W    - data word width
//
// Signals:
//   req_rd    - load request, sampled by the controller while ready=1
//   req_wr    - store request, sampled by the controller while ready=1
//   req_addr  - word address of the access
//   req_wdata - store data, already lane-organized
//   ready     - controller idle and accepting a request
//   done      - one-cycle pulse when an access completes
//   err       - sticky timeout flag, cleared by the next accepted request
//   rdata     - data of the last completed read
//
// Modports:
//   master    - datapath side (drives the request)
//   slave     - controller side (drives the response)
// ---------------------------------------------------------------------------
interface nvr_mem_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) ();

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_rd,
    output req_wr,
    output req_addr,
    output req_wdata,
    input  ready,
    input  done,
    input  err,
    input  rdata
  );

  modport slave (
    input  req_rd,
    input  req_wr,
    input  req_addr,
    input  req_wdata,
    output ready,
    output done,
    output err,
    output rdata
  );

endinterface

// File: rtl/nvr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// nvr_mem_ctrl
//
// Sequencer between the datapath and the NVR_TOP data memory macro. It turns
// a single-cycle load/store request into the NVR strobe sequence
// (address/WE setup, CE pulse, wait for RDY), returns the read data, and
// generates the NVR power-on POR pulse after every reset.
//
// Parameters:
//   ADDR_W       - NVR word address width (drives NVR A)
//   DATA_W       - data width
//   POR_LOW_CYC  - cycles POR is held low after reset release
//   POR_HIGH_CYC - POR pulse width in cycles
//   SETUP_CYC    - cycles A/DIN/WE are stable before CE rises (>= 1)
//   CE_CYC       - CE high width in cycles (>= 1)
//   MIN_WAIT     - cycles after CE falls before RDY at the pin is trusted
//   TIMEOUT      - max cycles spent waiting before the access is aborted
//
// Ports:
//   clk      - controller clock, rising edge
//   reset    - asynchronous active-low reset
//   bus      - request/response bus (slave side), see nvr_mem_ctrl_if
//   mem_a    - NVR A
//   mem_din  - NVR DIN
//   mem_ce   - NVR CE
//   mem_we   - NVR WE
//   mem_por  - NVR POR
//   mem_dout - NVR DOUT
//   mem_rdy  - NVR RDY, asynchronous to clk
// ---------------------------------------------------------------------------
module nvr_mem_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int POR_LOW_CYC  = 10,
  parameter int POR_HIGH_CYC = 10,
  parameter int SETUP_CYC    = 2,
  parameter int CE_CYC       = 1,
  parameter int MIN_WAIT     = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  nvr_mem_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_por,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rdy
);

  // The synchronized view of RDY lags the pin by SYNC_STAGES cycles, so rdy_s
  // only reflects a pin value taken at least MIN_WAIT cycles after the CE fall
  // once RDY_HOLDOFF cycles of WAIT have gone by. Anything earlier could be a
  // stale "ready" left over from before the strobe.
  localparam int SYNC_STAGES = 2;
  localparam int RDY_HOLDOFF = MIN_WAIT + SYNC_STAGES;

  // One shared counter serves every timed state; it must hold the largest
  // terminal value and is never narrower than 8 bits.
  localparam int MAX_POR = (POR_LOW_CYC > POR_HIGH_CYC) ? POR_LOW_CYC : POR_HIGH_CYC;
  localparam int MAX_STB = (SETUP_CYC > CE_CYC) ? SETUP_CYC : CE_CYC;
  localparam int MAX_WT  = (TIMEOUT > RDY_HOLDOFF) ? TIMEOUT : RDY_HOLDOFF;
  localparam int MAX_PS  = (MAX_POR > MAX_STB) ? MAX_POR : MAX_STB;
  localparam int MAX_ALL = (MAX_PS > MAX_WT) ? MAX_PS : MAX_WT;
  localparam int CNT_W   = ($clog2(MAX_ALL + 1) > 8) ? $clog2(MAX_ALL + 1) : 8;

  // Terminal counts: each timed state lasts exactly N cycles, so it leaves
  // when the count of cycles already spent there reaches N-1.
  localparam logic [CNT_W-1:0] CNT_MAX        = '1;
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] POR_LOW_LAST   = CNT_W'(POR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] POR_HIGH_LAST  = CNT_W'(POR_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST     = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] CE_LAST        = CNT_W'(CE_CYC - 1);
  localparam logic [CNT_W-1:0] RDY_OK_CNT     = CNT_W'(RDY_HOLDOFF);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_POR_PULSE,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               rdy_meta;
  logic               rdy_s;
  logic               accept;
  logic               wait_timeout;
  logic               ready_q;
  logic               done_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Two-flop synchronizer for the macro's RDY, which is not related to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= mem_rdy;
      rdy_s    <= rdy_meta;
    end
  end

  // State register and the shared cycle counter. Reset always restarts the
  // POR sequence, even in the middle of an access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_POR_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The counter saturates instead of wrapping so a stuck state can never
  // alias back to an early count.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Next-state logic. Every state transition restarts the counter at zero so
  // each timed state measures only its own cycles. In WAIT, a valid RDY takes
  // priority over the timeout when both happen in the same cycle.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt_inc;
    accept       = 1'b0;
    wait_timeout = 1'b0;
    case (state)
      ST_POR_WAIT: begin
        if (cnt >= POR_LOW_LAST) begin
          state_next = ST_POR_PULSE;
          cnt_next   = '0;
        end
      end
      ST_POR_PULSE: begin
        if (cnt >= POR_HIGH_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      ST_IDLE: begin
        cnt_next = '0;
        if (bus.req_rd || bus.req_wr) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt >= SETUP_LAST) begin
          state_next = ST_STROBE;
          cnt_next   = '0;
        end
      end
      ST_STROBE: begin
        if (cnt >= CE_LAST) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
        end
      end
      ST_WAIT: begin
        if (rdy_s && (cnt >= RDY_OK_CNT)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else if (cnt >= TIMEOUT_LAST) begin
          wait_timeout = 1'b1;
          state_next   = ST_DONE;
          cnt_next     = '0;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_POR_WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Status and strobe outputs are registered from the next state so the NVR
  // pins are driven straight from flops (no decode glitches on CE or POR),
  // while still changing on the same edge as the state itself. Because they
  // reset asynchronously, CE drops the moment reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      mem_ce  <= 1'b0;
      mem_por <= 1'b0;
    end else begin
      ready_q <= (state_next == ST_IDLE);
      done_q  <= (state_next == ST_DONE);
      mem_ce  <= (state_next == ST_STROBE);
      mem_por <= (state_next == ST_POR_PULSE);
    end
  end

  // Access registers. Address, write data and WE are captured only when a
  // request is accepted, so they stay put from SETUP through DONE and can
  // never move under an active CE. A simultaneous load and store becomes a
  // store. WE is released on the edge that leaves DONE. err is set on the
  // edge entering DONE after a timeout, so inside DONE it tells whether this
  // access timed out and the read data must not be taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_a   <= '0;
      mem_din <= '0;
      mem_we  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        mem_a   <= bus.req_addr;
        mem_din <= bus.req_wdata;
        mem_we  <= bus.req_wr;
        err_q   <= 1'b0;
      end
      if (wait_timeout) begin
        err_q <= 1'b1;
      end
      if (state == ST_DONE) begin
        mem_we <= 1'b0;
        if (!err_q && !mem_we) begin
          rdata_q <= mem_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_nvr_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nvr_mem_ctrl
//
// Directed self-checking bench for nvr_mem_ctrl. Inputs are driven 1 ns after
// a rising edge and outputs are sampled at the same point, so every sample
// shows the state produced by the edge just taken. "edges" counts rising
// edges taken by the stimulus process; latencies are measured from the edge
// that accepted a request.
// ---------------------------------------------------------------------------
module tb_nvr_mem_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_din;
  logic              mem_ce;
  logic              mem_we;
  logic              mem_por;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_rdy;

  int check_count = 0;
  int error_count = 0;
  int edges       = 0;

  nvr_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  nvr_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_a    (mem_a),
    .mem_din  (mem_din),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_por  (mem_por),
    .mem_dout (mem_dout),
    .mem_rdy  (mem_rdy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a one-cycle request while the controller is idle; returns the
  // edge count of the accepting edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, output int acc_edge);
    checkOutput("ready_before_req", bus.ready, 1);
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    acc_edge      = edges;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
  endtask

  // Bounded wait for the done pulse; a missing pulse is a failed check.
  task automatic waitDone(input string tag, input int acc_edge, output int lat);
    int guard;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    checkOutput(tag, bus.done, 1);
    lat = edges - acc_edge;
  endtask

  initial begin : stimulus
    int   acc;
    int   lat;
    int   rdy_edge;
    logic strobe_seen;
    logic done_early;

    reset         = 1'b0;
    mem_rdy       = 1'b1;
    mem_dout      = '0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    strobe_seen   = 1'b0;
    done_early    = 1'b0;

    // ---------------- reset state and POR sequence ----------------
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", bus.ready, 0);
    checkOutput("rst_por", mem_por, 0);
    checkOutput("rst_ce_we", {mem_ce, mem_we}, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (mem_ce || mem_we) strobe_seen = 1'b1;
      if (k == 9)  checkOutput("por_low_9", mem_por, 0);
      if (k == 10) checkOutput("por_rise_10", mem_por, 1);
      if (k == 19) begin
        checkOutput("por_high_19", mem_por, 1);
        checkOutput("por_ready_19", bus.ready, 0);
      end
      if (k == 20) begin
        checkOutput("por_fall_20", mem_por, 0);
        checkOutput("por_ready_20", bus.ready, 1);
      end
    end
    checkOutput("por_no_strobe", strobe_seen, 0);

    // ---------------- read, RDY already high ----------------
    mem_dout = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, 7'd3, 32'h0, acc);
    checkOutput("rd_ready_low", bus.ready, 0);
    checkOutput("rd_addr_s0", mem_a, 3);
    checkOutput("rd_we_s0", mem_we, 0);
    checkOutput("rd_ce_s0", mem_ce, 0);
    step();
    checkOutput("rd_ce_s1", mem_ce, 0);
    checkOutput("rd_addr_s1", mem_a, 3);
    step();
    checkOutput("rd_ce_strobe", mem_ce, 1);
    checkOutput("rd_addr_strobe", mem_a, 3);
    step();
    checkOutput("rd_ce_fall", mem_ce, 0);
    waitDone("rd_done", acc, lat);
    checkOutput("rd_latency", lat, 8);
    checkOutput("rd_err", bus.err, 0);
    step();
    checkOutput("rd_done_pulse", bus.done, 0);
    checkOutput("rd_ready_back", bus.ready, 1);
    checkOutput("rd_rdata", bus.rdata, 32'hDEADBEEF);

    // ---------------- write ----------------
    mem_dout = 32'h12345678;
    applyStimulus(1'b0, 1'b1, 7'd5, 32'h000000A5, acc);
    checkOutput("wr_we_setup", mem_we, 1);
    checkOutput("wr_ce_setup", mem_ce, 0);
    checkOutput("wr_addr", mem_a, 5);
    stepN(2);
    checkOutput("wr_ce_strobe", mem_ce, 1);
    checkOutput("wr_we_strobe", mem_we, 1);
    checkOutput("wr_din_strobe", mem_din, 32'hA5);
    waitDone("wr_done", acc, lat);
    checkOutput("wr_latency", lat, 8);
    checkOutput("wr_we_in_done", mem_we, 1);
    step();
    checkOutput("wr_we_released", mem_we, 0);
    checkOutput("wr_rdata_kept", bus.rdata, 32'hDEADBEEF);

    // ---------------- slow RDY ----------------
    mem_rdy  = 1'b0;
    mem_dout = 32'hCAFE0001;
    stepN(3);
    applyStimulus(1'b1, 1'b0, 7'd9, 32'h0, acc);
    stepN(3);
    checkOutput("slow_ce_fell", mem_ce, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) done_early = 1'b1;
    end
    checkOutput("slow_no_early_done", done_early, 0);
    mem_rdy  = 1'b1;
    rdy_edge = edges;
    waitDone("slow_done", acc, lat);
    checkOutput("slow_rdy_to_done", edges - rdy_edge, 3);
    checkOutput("slow_latency", lat, 26);
    checkOutput("slow_err", bus.err, 0);
    step();
    checkOutput("slow_rdata", bus.rdata, 32'hCAFE0001);

    // ---------------- timeout, with a request injected during WAIT ----------------
    mem_rdy  = 1'b0;
    mem_dout = 32'h5555AAAA;
    stepN(3);
    applyStimulus(1'b1, 1'b0, 7'd2, 32'h0, acc);
    stepN(5);
    bus.req_rd    = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 7'h7F;
    bus.req_wdata = 32'hFFFFFFFF;
    step();
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    checkOutput("wait_req_addr", mem_a, 2);
    checkOutput("wait_req_we", mem_we, 0);
    checkOutput("wait_req_din", mem_din, 0);
    checkOutput("wait_req_ready", bus.ready, 0);
    waitDone("to_done", acc, lat);
    checkOutput("to_latency", lat, 258);
    checkOutput("to_err", bus.err, 1);
    step();
    checkOutput("to_rdata_kept", bus.rdata, 32'hCAFE0001);
    checkOutput("to_err_sticky", bus.err, 1);
    checkOutput("to_ready_back", bus.ready, 1);

    // ---------------- next read clears err ----------------
    mem_rdy  = 1'b1;
    mem_dout = 32'h0BADF00D;
    stepN(3);
    applyStimulus(1'b1, 1'b0, 7'd4, 32'h0, acc);
    checkOutput("clr_err", bus.err, 0);
    waitDone("clr_done", acc, lat);
    checkOutput("clr_latency", lat, 8);
    step();
    checkOutput("clr_rdata", bus.rdata, 32'h0BADF00D);

    // ---------------- read and write together: write wins ----------------
    mem_dout = 32'hFFFF0000;
    applyStimulus(1'b1, 1'b1, 7'd6, 32'h00000066, acc);
    checkOutput("both_we", mem_we, 1);
    checkOutput("both_din", mem_din, 32'h66);
    waitDone("both_done", acc, lat);
    step();
    checkOutput("both_rdata_kept", bus.rdata, 32'h0BADF00D);

    // ---------------- reset while CE is high ----------------
    applyStimulus(1'b0, 1'b1, 7'd8, 32'h00000088, acc);
    stepN(2);
    checkOutput("mid_ce_high", mem_ce, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_ce_drop", mem_ce, 0);
    checkOutput("mid_we_drop", mem_we, 0);
    checkOutput("mid_ready", bus.ready, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) begin
        checkOutput("mid_por_low_9", mem_por, 0);
        checkOutput("mid_ready_9", bus.ready, 0);
      end
      if (k == 10) checkOutput("mid_por_rise_10", mem_por, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
